// File: rtl/breakout_pkg.sv
// Shared frame layout and status payload type for the breakout host serializer.
// Optional feature macro: PARITY_EN (adds an even-parity slot per lane).
package breakout_pkg;

`ifdef PARITY_EN
    localparam int unsigned FRAME_SLOTS = 13;
`else
    localparam int unsigned FRAME_SLOTS = 12;
`endif

    localparam int unsigned SLOT_START  = 0;
    localparam int unsigned SLOT_GAP    = 1;
    localparam int unsigned SLOT_DATA0  = 2;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned SLOT_LP_HI  = SLOT_DATA0 + DATA_BITS;
    localparam int unsigned SLOT_LP_LO  = SLOT_LP_HI + 1;
    localparam int unsigned SLOT_PARITY = SLOT_LP_LO + 1;
    localparam int unsigned STATUS_W    = 20;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);

    typedef struct packed {
        logic [7:0] port;
        logic [7:0] button;
        logic [3:0] link_pow;
    } status_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for quasi-static status inputs; no debounce.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture; both stages clear on reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/breakout_host_serializer.sv
// Breakout status serializer: 20 status bits framed onto two lanes plus a
// forwarded clock. Optional macro PARITY_EN appends an even-parity slot.
import breakout_pkg::*;

module breakout_host_serializer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_port,
    input  logic [7:0] i_button,
    input  logic [3:0] i_link_pow,
    output logic       o_clk,
    output logic       o_q0,
    output logic       o_q1
);

    localparam int unsigned       DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);

    status_t           w_in;
    status_t           w_sync;
    status_t           r_snap;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic              w_wrap;
    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        w_bit_idx;
    logic              w_q0;
    logic              w_q1;
    logic              r_clk;
    logic              r_q0;
    logic              r_q1;

    assign w_in = {i_port, i_button, i_link_pow};

    sync_2ff #(
        .WIDTH (STATUS_W)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (w_in),
        .o_q     (w_sync)
    );

    // Divider next value; a wrap marks the o_clk falling edge and a slot boundary
    always_comb begin
        w_wrap     = (r_div == DIV_LAST);
        w_div_next = w_wrap ? '0 : r_div + DIV_W'(1);
    end

    // Lane mux: selects the bit pair for the slot about to be driven
    always_comb begin
        w_q0      = 1'b0;
        w_q1      = 1'b0;
        w_bit_idx = 3'(SLOT_W'(SLOT_LP_HI - 1) - r_slot);
        if (r_slot == SLOT_W'(SLOT_START)) begin
            w_q0 = 1'b1;
            w_q1 = 1'b1;
        end else if (r_slot >= SLOT_W'(SLOT_DATA0) && r_slot < SLOT_W'(SLOT_LP_HI)) begin
            w_q0 = r_snap.port[w_bit_idx];
            w_q1 = r_snap.button[w_bit_idx];
        end else if (r_slot == SLOT_W'(SLOT_LP_HI)) begin
            w_q0 = r_snap.link_pow[3];
            w_q1 = r_snap.link_pow[1];
        end else if (r_slot == SLOT_W'(SLOT_LP_LO)) begin
            w_q0 = r_snap.link_pow[2];
            w_q1 = r_snap.link_pow[0];
`ifdef PARITY_EN
        end else if (r_slot == SLOT_W'(SLOT_PARITY)) begin
            w_q0 = (^r_snap.port) ^ r_snap.link_pow[3] ^ r_snap.link_pow[2];
            w_q1 = (^r_snap.button) ^ r_snap.link_pow[1] ^ r_snap.link_pow[0];
`endif
        end
    end

    // Divider, forwarded clock, slot counter, snapshot and lane registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div  <= '0;
            r_slot <= '0;
            r_snap <= '0;
            r_clk  <= 1'b0;
            r_q0   <= 1'b0;
            r_q1   <= 1'b0;
        end else begin
            r_div <= w_div_next;
            r_clk <= (w_div_next >= DIV_HALF);
            if (w_wrap) begin
                r_q0   <= w_q0;
                r_q1   <= w_q1;
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
                if (r_slot == SLOT_W'(SLOT_START)) begin
                    r_snap <= w_sync;
                end
            end
        end
    end

    assign o_clk = r_clk;
    assign o_q0  = r_q0;
    assign o_q1  = r_q1;

endmodule

// File: tb/tb_breakout_host_serializer.sv
// Self-checking bench for breakout_host_serializer (CLK_DIV=2, 10 ns clock).
// Honors PARITY_EN the same way as the design.
module tb_breakout_host_serializer;
    import breakout_pkg::*;

    localparam int CD = 2;
    localparam int FR = FRAME_SLOTS;

`ifdef PARITY_EN
    localparam logic [12:0] E0_A = 13'b1011110000101;
    localparam logic [12:0] E1_A = 13'b1010101010000;
    localparam logic [12:0] E0_B = 13'b1011110000110;
    localparam logic [12:0] E1_B = 13'b1010101010110;
`else
    localparam logic [12:0] E0_A = 13'b0101111000010;
    localparam logic [12:0] E1_A = 13'b0101010101000;
    localparam logic [12:0] E0_B = 13'b0101111000011;
    localparam logic [12:0] E1_B = 13'b0101010101011;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] port = 8'h00;
    logic [7:0] button = 8'h00;
    logic [3:0] lp = 4'h0;
    logic       o_clk, o_q0, o_q1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    breakout_host_serializer #(.CLK_DIV(CD)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_port     (port),
        .i_button   (button),
        .i_link_pow (lp),
        .o_clk      (o_clk),
        .o_q0       (o_q0),
        .o_q1       (o_q1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame contents for one slot, built directly from the frame description
    function automatic logic [1:0] slot_bits(input int k, input logic [19:0] s);
        logic [12:0] l0, l1;
        l0 = '0;
        l1 = '0;
        l0[0] = 1'b1;
        l1[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            l0[2+i] = s[19-i];
            l1[2+i] = s[11-i];
        end
        l0[10] = s[3];
        l1[10] = s[1];
        l0[11] = s[2];
        l1[11] = s[0];
        l0[12] = ^l0[11:2];
        l1[12] = ^l1[11:2];
        return {l0[k], l1[k]};
    endfunction

    // Reference model: cycle count since reset release decides clock phase and slot
    int          m_n = 0;
    int          m_k = -1;
    bit          m_valid = 1'b0;
    bit          m_drive = 1'b0;
    logic        m_clk = 1'b0, m_q0 = 1'b0, m_q1 = 1'b0;
    logic [19:0] m_snap = '0, m_h1 = '0, m_h2 = '0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        m_drive = 1'b0;
        if (rst) begin
            m_n  = 0;
            m_k  = -1;
            m_clk = 1'b0;
            m_q0 = 1'b0;
            m_q1 = 1'b0;
            m_h1 = '0;
            m_h2 = '0;
        end else begin
            m_n++;
            m_clk = ((m_n % CD) >= (CD / 2));
            if ((m_n % CD) == 0) begin
                m_k = ((m_n / CD) - 1) % FR;
                if (m_k == 0) m_snap = m_h2;
                {m_q0, m_q1} = slot_bits(m_k, m_snap);
                m_drive = 1'b1;
            end
            m_h2 = m_h1;
            m_h1 = {port, button, lp};
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_o_clk", 32'(o_clk), 32'(m_clk));
            chk("model_o_q0", 32'(o_q0), 32'(m_q0));
            chk("model_o_q1", 32'(o_q1), 32'(m_q1));
        end
    end

    task automatic wait_slot(input int k, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (m_drive && m_k == k) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_slot%0d: timeout got none expected slot", k);
        end
    endtask

    task automatic grab(input string name, input logic [12:0] e0, input logic [12:0] e1);
        logic [12:0] a0, a1;
        bit ok;
        int cyc;
        a0 = '0;
        a1 = '0;
        wait_slot(0, ok, cyc);
        if (!ok) return;
        a0[FR-1] = o_q0;
        a1[FR-1] = o_q1;
        for (int s = 1; s < FR; s++) begin
            wait_slot(s, ok, cyc);
            if (!ok) return;
            chk({name, "_spacing"}, 32'(cyc), 32'(CD));
            a0[FR-1-s] = o_q0;
            a1[FR-1-s] = o_q1;
        end
        chk({name, "_q0"}, 32'(a0), 32'(e0));
        chk({name, "_q1"}, 32'(a1), 32'(e1));
    endtask

    initial begin
        bit ok;
        int cyc;
        port = 8'hF0;
        button = 8'hAA;
        lp = 4'b1000;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_o_clk", 32'(o_clk), 32'd0);
        chk("reset_o_q0", 32'(o_q0), 32'd0);
        chk("reset_o_q1", 32'(o_q1), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("first_rise_o_clk", 32'(o_clk), 32'd1);
        chk("first_rise_q0", 32'(o_q0), 32'd0);
        @(negedge clk);
        chk("first_slot0_o_clk", 32'(o_clk), 32'd0);
        chk("first_slot0_q", 32'({o_q0, o_q1}), 32'd3);

        grab("frame2", E0_A, E1_A);
        grab("frame3", E0_A, E1_A);
        grab("frame4", E0_A, E1_A);

        wait_slot(4, ok, cyc);
        lp = 4'b1111;
        wait_slot(SLOT_LP_HI, ok, cyc);
        chk("old_lp_slot10", 32'({o_q0, o_q1}), 32'b10);
        wait_slot(SLOT_LP_LO, ok, cyc);
        chk("old_lp_slot11", 32'({o_q0, o_q1}), 32'b00);
        grab("new_lp", E0_B, E1_B);

        wait_slot(5, ok, cyc);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_o_clk", 32'(o_clk), 32'd0);
        chk("midreset_q", 32'({o_q0, o_q1}), 32'd0);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rerelease_rise", 32'({o_clk, o_q0, o_q1}), 32'b100);
        @(negedge clk);
        chk("rerelease_slot0", 32'({o_clk, o_q0, o_q1}), 32'b011);
        grab("after_reset", E0_B, E1_B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
